// File: rtl/his_builder_pkg.sv
// Shared defaults, derived index widths and bin-centre helper for the dToF histogram builder.
package his_builder_pkg;

    localparam int NP_DEF         = 10;
    localparam int PIXEL_NUM_DEF  = 6;
    localparam int PPR_DEF        = 3;
    localparam int PHOTON_NUM_DEF = 2;
    localparam int ACQ_NUM_DEF    = 2;
    localparam int BIN_BITS_DEF   = 3;
    localparam int CNT_W_DEF      = 4;
    localparam int GROUP_NUM_DEF  = PIXEL_NUM_DEF / PPR_DEF;

    typedef enum logic {ACC, REPORT} hisState_t;

    // Index width that stays legal for a single-entry range.
    function automatic int idxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GROUP_W_DEF = idxW(GROUP_NUM_DEF);

    function automatic int unsigned binCentre(input int unsigned b, input int np, input int binBits);
        return (b << (np - binBits)) + (32'd1 << (np - binBits - 1));
    endfunction

endpackage

// File: rtl/his_peak_finder.sv
// Combinational argmax over one pixel's bin counters, lowest bin wins ties.
// Zero latency; no flow control.
// allZero flags an empty histogram so the caller can report 0.
module his_peak_finder
    import his_builder_pkg::*;
#(
    parameter int BIN_BITS = BIN_BITS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic [CNT_W-1:0]    counts [1 << BIN_BITS],
    output logic [BIN_BITS-1:0] peakBin,
    output logic                allZero
);

    logic [CNT_W-1:0] best;

    always_comb begin
        best    = counts[0];
        peakBin = '0;
        // Strict compare keeps the earliest bin on equal counts.
        for (int i = 1; i < (1 << BIN_BITS); i++) begin
            if (counts[i] > best) begin
                best    = counts[i];
                peakBin = BIN_BITS'(i);
            end
        end
        allZero = (best == '0);
    end

endmodule

// File: rtl/his_builder_fsm.sv
// Per-pixel coarse histogram builder; reports each group's peak bin centres once per frame.
// Latency: peakValid rises one cycle after the REPORT cycle that follows a group's final beat.
// No backpressure: one beat per cycle sustained. HIS_DROP_SATURATED_EN drops all-ones "no photon" codes.
module his_builder_fsm
    import his_builder_pkg::*;
#(
    parameter int NP                = NP_DEF,
    parameter int PIXEL_NUM         = PIXEL_NUM_DEF,
    parameter int PIXEL_NUM_PER_RAM = PPR_DEF,
    parameter int PHOTON_NUM        = PHOTON_NUM_DEF,
    parameter int ACQ_NUM           = ACQ_NUM_DEF,
    parameter int BIN_BITS          = BIN_BITS_DEF,
    parameter int CNT_W             = CNT_W_DEF
) (
    input  logic                                               clk,
    input  logic                                               res,
    input  logic                                               wrEn,
    input  logic [NP-1:0]                                      data,
    output logic [NP-1:0]                                      peakResult [PIXEL_NUM_PER_RAM],
    output logic                                               peakValid,
    output logic [idxW(PIXEL_NUM / PIXEL_NUM_PER_RAM)-1:0]     peakGroup
);

    localparam int GROUP_NUM = PIXEL_NUM / PIXEL_NUM_PER_RAM;
    localparam int NBINS     = 1 << BIN_BITS;
    localparam int PHW       = idxW(PHOTON_NUM);
    localparam int PXW       = idxW(PIXEL_NUM_PER_RAM);
    localparam int GW        = idxW(GROUP_NUM);
    localparam int AW        = idxW(ACQ_NUM);
`ifdef HIS_DROP_SATURATED_EN
    localparam bit DROP_SAT  = 1'b1;
`else
    localparam bit DROP_SAT  = 1'b0;
`endif

    hisState_t            state;
    logic [PHW-1:0]       phIdx;
    logic [PXW-1:0]       pixIdx;
    logic [GW-1:0]        grpIdx;
    logic [AW-1:0]        acqIdx;
    logic [GW-1:0]        reportGroup;
    logic [CNT_W-1:0]     hist     [PIXEL_NUM][NBINS];
    logic [CNT_W-1:0]     laneHist [PIXEL_NUM_PER_RAM][NBINS];
    logic [BIN_BITS-1:0]  peakBin  [PIXEL_NUM_PER_RAM];
    logic [PIXEL_NUM_PER_RAM-1:0] allZero;
    logic [BIN_BITS-1:0]  bin;
    logic                 lastPh, lastPix, lastGrp, lastAcq, groupDone, countBeat;
    int                   curPix;

    assign bin       = data[NP-1 -: BIN_BITS];
    assign lastPh    = (phIdx  == PHW'(PHOTON_NUM - 1));
    assign lastPix   = (pixIdx == PXW'(PIXEL_NUM_PER_RAM - 1));
    assign lastGrp   = (grpIdx == GW'(GROUP_NUM - 1));
    assign lastAcq   = (acqIdx == AW'(ACQ_NUM - 1));
    assign groupDone = wrEn && lastPh && lastPix && lastAcq;
    assign countBeat = wrEn && !(DROP_SAT && (&data));

    always_comb curPix = int'(grpIdx) * PIXEL_NUM_PER_RAM + int'(pixIdx);

    // Beat counters and histogram storage; a clear and an increment on the same
    // counter leave it at 1.
    always_ff @(posedge clk) begin
        if (res) begin
            phIdx  <= '0;
            pixIdx <= '0;
            grpIdx <= '0;
            acqIdx <= '0;
            for (int px = 0; px < PIXEL_NUM; px++)
                for (int b = 0; b < NBINS; b++)
                    hist[px][b] <= '0;
        end else begin
            if (wrEn) begin
                phIdx <= lastPh ? '0 : phIdx + PHW'(1);
                if (lastPh) begin
                    pixIdx <= lastPix ? '0 : pixIdx + PXW'(1);
                    if (lastPix) begin
                        grpIdx <= lastGrp ? '0 : grpIdx + GW'(1);
                        if (lastGrp)
                            acqIdx <= lastAcq ? '0 : acqIdx + AW'(1);
                    end
                end
            end
            for (int px = 0; px < PIXEL_NUM; px++) begin
                for (int b = 0; b < NBINS; b++) begin
                    if (countBeat && px == curPix && b == int'(bin)) begin
                        if (state == REPORT && px / PIXEL_NUM_PER_RAM == int'(reportGroup))
                            hist[px][b] <= CNT_W'(1);
                        else if (!(&hist[px][b]))
                            hist[px][b] <= hist[px][b] + CNT_W'(1);
                    end else if (state == REPORT && px / PIXEL_NUM_PER_RAM == int'(reportGroup)) begin
                        hist[px][b] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < PIXEL_NUM_PER_RAM; p++)
            for (int b = 0; b < NBINS; b++)
                laneHist[p][b] = '0;
        for (int px = 0; px < PIXEL_NUM; px++)
            if (px / PIXEL_NUM_PER_RAM == int'(reportGroup))
                for (int b = 0; b < NBINS; b++)
                    laneHist[px % PIXEL_NUM_PER_RAM][b] = hist[px][b];
    end

    for (genvar p = 0; p < PIXEL_NUM_PER_RAM; p++) begin : gLane
        his_peak_finder #(
            .BIN_BITS (BIN_BITS),
            .CNT_W    (CNT_W)
        ) uPeak (
            .counts  (laneHist[p]),
            .peakBin (peakBin[p]),
            .allZero (allZero[p])
        );
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= ACC;
            reportGroup <= '0;
            peakValid   <= 1'b0;
            peakGroup   <= '0;
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++)
                peakResult[p] <= '0;
        end else begin
            peakValid <= 1'b0;
            if (state == REPORT) begin
                peakValid <= 1'b1;
                peakGroup <= reportGroup;
                for (int p = 0; p < PIXEL_NUM_PER_RAM; p++)
                    peakResult[p] <= allZero[p] ? '0
                                   : NP'(binCentre(32'(peakBin[p]), NP, BIN_BITS));
            end
            if (groupDone) begin
                state       <= REPORT;
                reportGroup <= grpIdx;
            end else begin
                state <= ACC;
            end
        end
    end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Directed self-checking bench for his_builder_fsm at default parameters.
module tb_his_builder_fsm;
    import his_builder_pkg::*;

    typedef int frame_t [24];

`ifdef HIS_DROP_SATURATED_EN
    localparam int EXP_ALLONES_PIX = 0;
    localparam int EXP_G1_LANE2    = 64;
`else
    localparam int EXP_ALLONES_PIX = 960;
    localparam int EXP_G1_LANE2    = 960;
`endif

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          wrEn = 1'b0;
    logic [9:0]    data = '0;
    logic [9:0]    peakResult [3];
    logic          peakValid;
    logic [0:0]    peakGroup;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    int lastBeatCyc, g0Cyc, g1Cyc;
    int nCap = 0;
    int capCyc [16];
    int capGrp [16];
    int capRes [16][3];

    frame_t stdF = '{108, 511, 1022, 1022, 200, 90, 700, 710, 130, 260, 1023, 0,
                     300, 500, 50, 1000, 48, 90, 720, 100, 390, 900, 1023, 1023};
    frame_t tieF = '{108, 511, 1023, 1023, 640, 640, 0, 0, 0, 0, 0, 0,
                     108, 511, 1023, 1023, 640, 640, 0, 0, 0, 0, 0, 0};
    int expG0 [3] = '{448, 960, 64};
    int expG1 [3] = '{704, 192, EXP_G1_LANE2};
    int expTie [3] = '{64, EXP_ALLONES_PIX, 704};

    his_builder_fsm dut (
        .clk        (clk),
        .res        (res),
        .wrEn       (wrEn),
        .data       (data),
        .peakResult (peakResult),
        .peakValid  (peakValid),
        .peakGroup  (peakGroup)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (peakValid && nCap < 16) begin
            capCyc[nCap] = cyc;
            capGrp[nCap] = int'(peakGroup);
            for (int p = 0; p < 3; p++) capRes[nCap][p] = int'(peakResult[p]);
            nCap = nCap + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wrEn = 1'b0;
        end
    endtask

    task automatic sendBeat(input int d);
        @(negedge clk);
        wrEn = 1'b1;
        data = 10'(d);
        lastBeatCyc = cyc + 1;
    endtask

    task automatic sendFrame(input frame_t f, input int gap);
        for (int i = 0; i < 24; i++) begin
            if (i == 12 && gap > 0) idle(gap);
            sendBeat(f[i]);
            if (i == 17) g0Cyc = lastBeatCyc;
            if (i == 23) g1Cyc = lastBeatCyc;
        end
    endtask

    task automatic test_reset();
        res = 1'b1; wrEn = 1'b1; data = 10'h3FF;
        repeat (2) @(negedge clk);
        res = 1'b0; wrEn = 1'b0;
        for (int p = 0; p < 3; p++) begin
            nChecks++;
            if (peakResult[p] !== 10'd0) begin
                nFail++; $display("FAIL reset_result%0d: got %0d expected 0", p, peakResult[p]);
            end
        end
        nChecks++;
        if (peakValid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %0b expected 0", peakValid); end
        nChecks++;
        if (peakGroup !== 1'b0) begin nFail++; $display("FAIL reset_group: got %0d expected 0", peakGroup); end
    endtask

    task automatic test_frame();
        int base;
        base = nCap;
        sendFrame(stdF, 4);
        idle(4);
        nChecks++;
        if (nCap - base != 2) begin nFail++; $display("FAIL frame_count: got %0d expected 2", nCap - base); end
        nChecks++;
        if (capGrp[base] != 0 || capCyc[base] != g0Cyc + 1) begin
            nFail++; $display("FAIL frame_g0_timing: got grp %0d cyc %0d expected grp 0 cyc %0d", capGrp[base], capCyc[base], g0Cyc + 1);
        end
        nChecks++;
        if (capGrp[base+1] != 1 || capCyc[base+1] != g1Cyc + 1) begin
            nFail++; $display("FAIL frame_g1_timing: got grp %0d cyc %0d expected grp 1 cyc %0d", capGrp[base+1], capCyc[base+1], g1Cyc + 1);
        end
        for (int p = 0; p < 3; p++) begin
            nChecks++;
            if (capRes[base][p] != expG0[p]) begin
                nFail++; $display("FAIL frame_g0_lane%0d: got %0d expected %0d", p, capRes[base][p], expG0[p]);
            end
            nChecks++;
            if (capRes[base+1][p] != expG1[p]) begin
                nFail++; $display("FAIL frame_g1_lane%0d: got %0d expected %0d", p, capRes[base+1][p], expG1[p]);
            end
        end
        nChecks++;
        if (peakValid !== 1'b0 || peakGroup !== 1'b1 || peakResult[1] !== 10'd192) begin
            nFail++; $display("FAIL frame_hold: got valid %0b grp %0d res1 %0d expected 0 1 192", peakValid, peakGroup, peakResult[1]);
        end
    endtask

    task automatic test_tie_macro();
        int base;
        base = nCap;
        sendFrame(tieF, 0);
        idle(4);
        nChecks++;
        if (nCap - base != 2) begin nFail++; $display("FAIL tie_count: got %0d expected 2", nCap - base); end
        for (int p = 0; p < 3; p++) begin
            nChecks++;
            if (capRes[base][p] != expTie[p]) begin
                nFail++; $display("FAIL tie_lane%0d: got %0d expected %0d", p, capRes[base][p], expTie[p]);
            end
        end
        nChecks++;
        if (capRes[base+1][0] != 64) begin nFail++; $display("FAIL tie_g1_zero_data: got %0d expected 64", capRes[base+1][0]); end
    endtask

    task automatic test_mid_reset();
        int base;
        for (int i = 0; i < 5; i++) sendBeat(1000);
        @(negedge clk);
        res = 1'b1; wrEn = 1'b0;
        @(negedge clk);
        res = 1'b0;
        nChecks++;
        if (peakResult[0] !== 10'd0 || peakValid !== 1'b0) begin
            nFail++; $display("FAIL midreset_outputs: got res0 %0d valid %0b expected 0 0", peakResult[0], peakValid);
        end
        base = nCap;
        sendFrame(stdF, 4);
        idle(4);
        nChecks++;
        if (nCap - base != 2) begin nFail++; $display("FAIL midreset_count: got %0d expected 2", nCap - base); end
        for (int p = 0; p < 3; p++) begin
            nChecks++;
            if (capRes[base][p] != expG0[p] || capRes[base+1][p] != expG1[p]) begin
                nFail++; $display("FAIL midreset_lane%0d: got %0d/%0d expected %0d/%0d", p, capRes[base][p], capRes[base+1][p], expG0[p], expG1[p]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = nCap;
        sendFrame(tieF, 0);
        sendFrame(stdF, 0);
        idle(4);
        nChecks++;
        if (nCap - base != 4) begin nFail++; $display("FAIL b2b_count: got %0d expected 4", nCap - base); end
        nChecks++;
        if (capCyc[base+3] != g1Cyc + 1 || capGrp[base+2] != 0) begin
            nFail++; $display("FAIL b2b_timing: got cyc %0d grp %0d expected cyc %0d grp 0", capCyc[base+3], capGrp[base+2], g1Cyc + 1);
        end
        for (int p = 0; p < 3; p++) begin
            nChecks++;
            if (capRes[base+2][p] != expG0[p] || capRes[base+3][p] != expG1[p]) begin
                nFail++; $display("FAIL b2b_lane%0d: got %0d/%0d expected %0d/%0d", p, capRes[base+2][p], capRes[base+3][p], expG0[p], expG1[p]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_tie_macro();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/his_builder_fsm.md
# his_builder_fsm

Per-pixel coarse histogram builder for the dToF pipeline. It sits after the TDC front end and consumes one time-of-flight timestamp per `wrEn` beat. It accumulates the timestamps into per-pixel coarse-bin histograms over `ACQ_NUM` acquisitions. It then reports, for each group of `PIXEL_NUM_PER_RAM` pixels, the bin-centre time of each pixel's histogram peak to the downstream depth stage.

## Interface
Parameters:
- `NP`, 10: timestamp width in bits; also the width of each peak result.
- `PIXEL_NUM`, 6: total pixels. Must be a multiple of `PIXEL_NUM_PER_RAM`.
- `PIXEL_NUM_PER_RAM`, 3: pixels per group, which is also the number of result lanes. `GROUP_NUM = PIXEL_NUM/PIXEL_NUM_PER_RAM`.
- `PHOTON_NUM`, 2: timestamps per pixel per acquisition.
- `ACQ_NUM`, 2: acquisitions per histogram frame.
- `BIN_BITS`, 3: number of timestamp MSBs used as the bin index, giving 2^BIN_BITS bins.
- `CNT_W`, 4: bin counter width. Counters saturate.

Ports (reset is synchronous and active-high, `res`):
- `clk` in 1: single clock; all state updates on the rising edge.
- `res` in 1: synchronous, active-high reset.
- `wrEn` in 1: `data` is valid this cycle.
- `data` in `NP`: timestamp.
- `peakResult` out `NP` × `PIXEL_NUM_PER_RAM` (unpacked array): peak bin-centre time per pixel of the reported group; registered.
- `peakValid` out 1: one-cycle pulse when `peakResult` is updated.
- `peakGroup` out clog2(`GROUP_NUM`): index of the reported group.

## Operation
- **Stream order.** The beat index counters advance only on `wrEn`, fastest first: photon (0..`PHOTON_NUM`-1), then pixel-in-group (0..`PIXEL_NUM_PER_RAM`-1), then group (0..`GROUP_NUM`-1), then acquisition (0..`ACQ_NUM`-1). Everything wraps to 0 after the last beat of the last acquisition.
- **Binning.** `bin = data[NP-1 -: BIN_BITS]`. Each beat increments `hist[group*PIXEL_NUM_PER_RAM+pixel][bin]`, saturating at 2^CNT_W-1.
- **FSM states.**
  - ACC: accumulating.
  - REPORT: lasts one cycle. It is entered after the beat that completes group g in acquisition `ACQ_NUM`-1.
- **In REPORT:**
  - For each lane p, take the peak bin b = argmax of group g's histogram for that pixel. Ties go to the lowest bin.
  - `peakResult[p] = (b << (NP-BIN_BITS)) + 2^(NP-BIN_BITS-1)`. If all of that pixel's counts are zero, `peakResult[p] = 0`.
  - `peakValid = 1`, `peakGroup = g`.
  - Group g's histograms are cleared.
  - The FSM returns to ACC.
- **`wrEn` during REPORT** is accepted and processed normally. If that beat targets a histogram being cleared (only possible when `GROUP_NUM=1`), the clear applies first and then the increment, so the target bin ends at 1.
- **Output hold.** `peakResult` and `peakGroup` hold their values until the next REPORT.
- **Gaps.** Idle cycles (`wrEn=0`) between beats or between acquisitions have no effect; `data` is ignored when `wrEn=0`.

## Timing
- **Reset (`res=1` at an edge):**
  - All index counters are cleared.
  - All histograms are cleared.
  - State returns to ACC.
  - Outputs go to `peakResult` = 0, `peakValid` = 0, `peakGroup` = 0.
  - Reset takes priority over `wrEn`.
- **Reset mid-frame** discards the partial frame. The next beat is treated as photon 0 / pixel 0 / group 0 / acquisition 0.
- **Latency.** If the last beat of group g in the final acquisition is sampled at edge k, then `peakValid` is high for the cycle after edge k+1, carrying `peakResult`/`peakGroup`. The peak is computed from histogram contents as of edge k, including that last beat.
- **No backpressure.** The block accepts one beat per cycle sustained.

## Configuration
- `HIS_DROP_SATURATED_EN`:
  - Defined: `data` equal to all-ones (2^NP-1) is a "no photon" code. It advances the index counters but increments no bin.
  - Undefined: all-ones is an ordinary timestamp, landing in the top bin.

## Structure
- **Package `his_builder_pkg`:** default parameter constants, derived `GROUP_NUM`/index widths, and a bin-centre function.
- **Sub-module `his_peak_finder`:** combinational argmax over 2^BIN_BITS counters with lowest-index tie-break. It returns the bin and an all-zero flag, and is instantiated once per lane.
- **Top:** counters, histogram register array, FSM, and output registers.

## Test plan
All scenarios use default parameters and macro undefined unless stated.
- **Reset:** hold `res` for 2 cycles → `peakResult` all 0, `peakValid` 0, `peakGroup` 0.
- **Two-acquisition frame** with a 4-cycle idle gap between acquisitions.
  - Group 0, pixel 0: 108, 511 / 300, 500 → 448.
  - Group 0, pixel 1: 1022, 1022 / 50, 1000 → 960.
  - Group 0, pixel 2: 200, 90 / 48, 90 → 64.
  - `peakValid` pulses with `peakGroup`=0 one cycle after the 18th beat; group 1 is reported after beat 24.
- **Tie:** one pixel gets 108, 511, 108, 511 → 64 (bin 0 beats bin 3).
- **Macro defined:** one pixel gets all four samples = 1023 → `peakResult` 0. Same stimulus with macro undefined → 960.
- **Mid-frame reset:** assert `res` after 5 beats, then replay the full frame from scenario 2 → results identical to scenario 2.
- **Back-to-back frames:** the second frame's results are unaffected by the first frame, confirming histograms were cleared on REPORT.
